// File: rtl/ula_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module  : ula_pixel_fetch
// Brief   : ULA display-fetch stage. Generates Spectrum screen-memory
//           addresses for the VGA-doubled 256x192 picture, captures bitmap
//           and attribute bytes, serializes pixels and resolves
//           ink/paper/bright/flash into a 4-bit colour index, substituting
//           the border colour outside the picture.
// Revision: 1.0 - initial release
// ============================================================================
module ula_pixel_fetch #(
  parameter int H_START = 64,
  parameter int V_START = 48,
  parameter int RAM_LAT = 2
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [2:0]  border,
  output logic [12:0] vram_address,
  input  logic [7:0]  vram_data,
  output logic [3:0]  color,
  output logic        in_screen
);

  // Raster extents (11 bits so the limits never wrap for any legal start)
  localparam logic [10:0] c_H_TOTAL = 11'd800;
  localparam logic [10:0] c_V_TOTAL = 11'd525;
  localparam logic [10:0] c_H_LO    = 11'(H_START);
  localparam logic [10:0] c_H_HI    = 11'(H_START + 512);
  localparam logic [10:0] c_V_LO    = 11'(V_START);
  localparam logic [10:0] c_V_HI    = 11'(V_START + 384);
  // Fetch runs one 16-clock cell ahead of display; cell 31 is the last one
  localparam logic [10:0] c_F_LO    = 11'(H_START - 16);
  localparam logic [10:0] c_F_HI    = 11'(H_START + 496);

  // Fetch phases within a cell; capture phases trail the address by RAM_LAT
  localparam logic [3:0]  c_PH_BMP_ADDR = 4'd0;
  localparam logic [3:0]  c_PH_ATR_ADDR = 4'd1;
  localparam logic [3:0]  c_PH_BMP_CAP  = 4'(RAM_LAT);
  localparam logic [3:0]  c_PH_ATR_CAP  = 4'(RAM_LAT + 1);
  localparam logic [3:0]  c_PH_XFER     = 4'd15;

  localparam logic [12:0] c_ATTR_BASE   = 13'h1800;

  // Window / position decode
  logic [10:0] w_hc;
  logic [10:0] w_vc;
  logic        w_h_in;
  logic        w_v_in;
  logic        w_in_win;
  logic        w_h_odd;
  logic [7:0]  w_y;
  logic        w_fetch;
  logic [8:0]  w_f_off;
  logic [4:0]  w_cell;
  logic [3:0]  w_phase;

  // Registered state
  logic [7:0]  r_bmp_hold;
  logic [7:0]  r_atr_hold;
  logic [7:0]  r_shift;
  logic [7:0]  r_attr;
  logic [4:0]  r_flash_cnt;

  // First output pipeline stage
  logic        r_pix1;
  logic [7:0]  r_attr1;
  logic        r_win1;
  logic [2:0]  r_border1;

  // Colour resolution
  logic        w_swap;
  logic [2:0]  w_ink;
  logic [2:0]  w_paper;
  logic [3:0]  w_color_next;

  assign w_hc     = {1'b0, hcount};
  assign w_vc     = {1'b0, vcount};
  assign w_h_in   = (w_hc >= c_H_LO) && (w_hc < c_H_HI) && (w_hc < c_H_TOTAL);
  assign w_v_in   = (w_vc >= c_V_LO) && (w_vc < c_V_HI) && (w_vc < c_V_TOTAL);
  assign w_in_win = w_h_in && w_v_in;

  // Each Spectrum pixel spans two clocks; shift after the second one
  assign w_h_odd  = 1'(hcount - 10'(H_START));
  assign w_y      = 8'((vcount - 10'(V_START)) >> 1);

  assign w_fetch  = w_v_in && (w_hc >= c_F_LO) && (w_hc < c_F_HI);
  assign w_f_off  = 9'(hcount - 10'(H_START - 16));
  assign w_cell   = w_f_off[8:4];
  assign w_phase  = w_f_off[3:0];

  // Screen-RAM address: bitmap then attribute at the start of each fetch
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      vram_address <= 13'h0000;
    end else if (w_fetch) begin
      if (w_phase == c_PH_BMP_ADDR) begin
        vram_address <= {w_y[7:6], w_y[2:0], w_y[5:3], w_cell};
      end else if (w_phase == c_PH_ATR_ADDR) begin
        vram_address <= c_ATTR_BASE + {3'b000, w_y[7:3], w_cell};
      end
    end
  end

  // Capture RAM data, hand it to the display registers and serialize pixels
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      r_bmp_hold <= 8'h00;
      r_atr_hold <= 8'h00;
      r_shift    <= 8'h00;
      r_attr     <= 8'h00;
    end else begin
      if (w_fetch && (w_phase == c_PH_BMP_CAP)) begin
        r_bmp_hold <= vram_data;
      end
      if (w_fetch && (w_phase == c_PH_ATR_CAP)) begin
        r_atr_hold <= vram_data;
      end
      // The transfer lands on the last odd offset of the previous cell,
      // so it takes priority over the shift on that clock
      if (w_fetch && (w_phase == c_PH_XFER)) begin
        r_shift <= r_bmp_hold;
        r_attr  <= r_atr_hold;
      end else if (w_in_win && w_h_odd) begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
    end
  end

  // Frame counter driving the flash phase (toggles every 16 frames)
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      r_flash_cnt <= 5'd0;
    end else if ((hcount == 10'd0) && (vcount == 10'd0)) begin
      r_flash_cnt <= r_flash_cnt + 5'd1;
    end
  end

  // First pipeline stage: freeze pixel, attribute, window flag and border
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      r_pix1    <= 1'b0;
      r_attr1   <= 8'h00;
      r_win1    <= 1'b0;
      r_border1 <= 3'b000;
    end else begin
      r_pix1    <= r_shift[7];
      r_attr1   <= r_attr;
      r_win1    <= w_in_win;
      r_border1 <= border;
    end
  end

  assign w_swap       = r_attr1[7] & r_flash_cnt[4];
  assign w_ink        = w_swap ? r_attr1[5:3] : r_attr1[2:0];
  assign w_paper      = w_swap ? r_attr1[2:0] : r_attr1[5:3];
  assign w_color_next = r_win1 ? {r_attr1[6], (r_pix1 ? w_ink : w_paper)}
                               : {1'b0, r_border1};

  // Second pipeline stage: registered colour index and window flag
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      color     <= 4'h0;
      in_screen <= 1'b0;
    end else begin
      color     <= w_color_next;
      in_screen <= r_win1;
    end
  end

endmodule
`default_nettype wire
